// File: rtl/adau1761_spi_responder.sv
// ADAU1761 control-port SPI target: oversamples the SPI pins, decodes
// chip/subaddress/data frames, serves a small register window and mirrors writes.
module adau1761_spi_responder #(
   parameter logic [15:0] BASE_ADDR = 16'h4000,
   parameter int          DEPTH     = 64,
   parameter int          INIT_CS   = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sclk,
   input  logic        cs,
   input  logic        sdi,
   output logic        sdo,
   output logic        spi_mode,
   output logic        wr_valid,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      WAIT_MODE, IDLE, CHIP, SUB, WDATA, RDATA, IGNORE
   } state_t;

   state_t      state;
   logic [7:0]  regs [DEPTH];
   logic        sclk_p0, sclk_p1, sclk_p2;
   logic        cs_p0, cs_p1, cs_p2;
   logic        sdi_p0, sdi_p1;
   logic [14:0] shreg;
   logic [3:0]  bit_cnt;
   logic [7:0]  mode_cnt;
   logic        rw;
   logic [15:0] addr;
   logic [7:0]  rd_byte;

   logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [7:0]  rx_byte, sub_rd, next_rd;
   logic [15:0] sub_addr, next_addr;

   function automatic logic in_window(input logic [15:0] a);
      logic [15:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ({1'b0, off} < 17'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] win_idx(input logic [15:0] a);
      logic [15:0] off;
      off = a - BASE_ADDR;
      return off[IDX_W-1:0];
   endfunction

   // p0/p1: two-flop synchronisers; p2: delayed copy for edge detection
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         sclk_p2 <= 1'b0;
         cs_p0   <= 1'b1;
         cs_p1   <= 1'b1;
         cs_p2   <= 1'b1;
         sdi_p0  <= 1'b0;
         sdi_p1  <= 1'b0;
      end else begin
         sclk_p0 <= sclk;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         cs_p0   <= cs;
         cs_p1   <= cs_p0;
         cs_p2   <= cs_p1;
         sdi_p0  <= sdi;
         sdi_p1  <= sdi_p0;
      end
   end

   always_comb begin
      sclk_rise = sclk_p1 & ~sclk_p2;
      sclk_fall = ~sclk_p1 & sclk_p2;
      cs_rise   = cs_p1 & ~cs_p2;
      cs_fall   = ~cs_p1 & cs_p2;
      rx_byte   = {shreg[6:0], sdi_p1};
      sub_addr  = {shreg, sdi_p1};
      next_addr = addr + 16'd1;
      sub_rd    = in_window(sub_addr) ? regs[win_idx(sub_addr)] : 8'h00;
      next_rd   = in_window(next_addr) ? regs[win_idx(next_addr)] : 8'h00;
   end

   // frame decoder, register window and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= WAIT_MODE;
         sdo      <= 1'b0;
         spi_mode <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= 16'h0000;
         wr_data  <= 8'h00;
         shreg    <= '0;
         bit_cnt  <= 4'd0;
         mode_cnt <= 8'd0;
         rw       <= 1'b0;
         addr     <= 16'h0000;
         rd_byte  <= 8'h00;
         for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
      end else begin
         wr_valid <= 1'b0;
         if (state != WAIT_MODE && cs_rise) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            sdo     <= 1'b0;
         end else begin
            if (sclk_rise && !cs_p1 && state != WAIT_MODE)
               shreg <= {shreg[13:0], sdi_p1};
            case (state)
               WAIT_MODE: begin
                  sdo <= 1'b0;
                  if (cs_rise) begin
                     if (mode_cnt == 8'(INIT_CS - 1)) begin
                        spi_mode <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        mode_cnt <= mode_cnt + 8'd1;
                     end
                  end
               end
               IDLE: begin
                  sdo <= 1'b0;
                  if (cs_fall) begin
                     state   <= CHIP;
                     bit_cnt <= 4'd0;
                  end
               end
               CHIP: begin
                  if (sclk_rise && !cs_p1) begin
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        if (rx_byte[7:1] != 7'd0) begin
                           state <= IGNORE;
                        end else begin
                           rw    <= rx_byte[0];
                           state <= SUB;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               SUB: begin
                  if (sclk_rise && !cs_p1) begin
                     if (bit_cnt == 4'd15) begin
                        bit_cnt <= 4'd0;
                        addr    <= sub_addr;
                        if (rw) begin
                           state   <= RDATA;
                           rd_byte <= sub_rd;
                           sdo     <= sub_rd[7];
                        end else begin
                           state <= WDATA;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               WDATA: begin
                  if (sclk_rise && !cs_p1) begin
                     if (bit_cnt == 4'd7) begin
                        bit_cnt  <= 4'd0;
                        wr_valid <= 1'b1;
                        wr_addr  <= addr;
                        wr_data  <= rx_byte;
                        if (in_window(addr)) regs[win_idx(addr)] <= rx_byte;
                        addr     <= next_addr;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               RDATA: begin
                  // bit_cnt counts rises within the byte, so the fall after a
                  // byte boundary re-presents the MSB of the freshly loaded byte
                  if (sclk_rise && !cs_p1) begin
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        addr    <= next_addr;
                        rd_byte <= next_rd;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end else if (sclk_fall && !cs_p1) begin
                     sdo <= rd_byte[3'd7 - bit_cnt[2:0]];
                  end
               end
               IGNORE: begin
                  sdo <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  sdo   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
